// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised single-bus datapath.
package datapath_pkg;

    // ALU operation select; codes 13..15 are unassigned and produce zero.
    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluNot  = 4'd4,
        AluNeg  = 4'd5,
        AluShr  = 4'd6,
        AluShra = 4'd7,
        AluShl  = 4'd8,
        AluRor  = 4'd9,
        AluRol  = 4'd10,
        AluMul  = 4'd11,
        AluDiv  = 4'd12
    } alu_op_e;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    // Bus sources after the general registers, listed in falling priority.
    localparam int unsigned SrcHi       = 0;
    localparam int unsigned SrcLo       = 1;
    localparam int unsigned SrcZhi      = 2;
    localparam int unsigned SrcZlo      = 3;
    localparam int unsigned SrcPc       = 4;
    localparam int unsigned SrcMdr      = 5;
    localparam int unsigned SrcC        = 6;
    localparam int unsigned NumFixedSrc = 7;

    // True for the ops handled by the multi-cycle sequencer.
    function automatic logic is_seq_op(input logic [3:0] op);
        return (op == AluMul) || (op == AluDiv);
    endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Multi-cycle signed multiply / divide sequencer: one shift-add or
// restoring-subtract step per cycle on operand magnitudes, sign fix-up at the end.
module mul_div_seq
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             idle,
    output logic             accept,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    seq_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               div0_q, div0_d;
    logic               is_div_q, a_neg_q, b_neg_q, b_zero_q;
    logic [WIDTH-1:0]   b_mag_q;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to itself, still correct unsigned.
    assign a_mag  = opa[WIDTH-1] ? -opa : opa;
    assign b_mag  = opb[WIDTH-1] ? -opb : opb;
    assign accept = start && (state_q == StIdle) && is_seq_op(op);
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign idle   = (state_q == StIdle);
    assign div0   = div0_q;

    // One iteration: p holds {accumulator, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_mag_q} : '0);
        mul_next  = {mul_sum, p_q[WIDTH-1:1]};
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        // Remainder stays below the divisor, so the top shifted bit is always zero.
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end
        step = is_div_q ? div_next : mul_next;
    end

    // Sign correction applied to the final step's value.
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -step : step;
        rem_fix  = a_neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        // With a zero divisor every trial succeeds, so the remainder is already the dividend.
        if (b_zero_q) begin
            quo_fix = '1;
        end else begin
            quo_fix = (a_neg_q ^ b_neg_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        end
        res_hi = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // FSM next-state, iteration counter and working register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        div0_d    = div0_q;
        res_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    p_d     = {{WIDTH{1'b0}}, a_mag};
                    div0_d  = 1'b0;
                end
            end
            StRun: begin
                p_d   = step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d   = StDone;
                    res_valid = 1'b1;
                    div0_d    = is_div_q && b_zero_q;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state, counter and working register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            div0_q  <= div0_d;
        end
    end

    // Operand signs, divisor magnitude and op kind captured only at launch.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            b_mag_q  <= '0;
        end else if (accept) begin
            is_div_q <= (op == AluDiv);
            a_neg_q  <= opa[WIDTH-1];
            b_neg_q  <= opb[WIDTH-1];
            b_zero_q <= (opb == '0);
            b_mag_q  <= b_mag;
        end
    end

endmodule

// File: rtl/datapath_gen.sv
// Single-bus CPU datapath: register file, HI/LO/PC/MDR/Y/Z, ALU and mul/div sequencer.
module datapath_gen
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       mdatain,
    input  logic                   readMDR,
    input  logic [NREGS-1:0]       reg_in,
    input  logic [NREGS-1:0]       reg_out,
    input  logic                   HIin,
    input  logic                   LOin,
    input  logic                   PCin,
    input  logic                   MDRin,
    input  logic                   Yin,
    input  logic                   Zin,
    input  logic                   HIout,
    input  logic                   LOout,
    input  logic                   PCout,
    input  logic                   MDRout,
    input  logic                   ZHIout,
    input  logic                   ZLOout,
    input  logic                   Cout,
    input  logic [WIDTH-1:0]       csign,
    input  logic [3:0]             alu_op,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   div0,
    output logic [WIDTH-1:0]       bus_out,
    output logic [NREGS*WIDTH-1:0] r_flat,
    output logic [WIDTH-1:0]       HI,
    output logic [WIDTH-1:0]       LO,
    output logic [WIDTH-1:0]       PC,
    output logic [WIDTH-1:0]       MDR,
    output logic [WIDTH-1:0]       RY,
    output logic [WIDTH-1:0]       ZHI,
    output logic [WIDTH-1:0]       ZLO
);

    localparam int unsigned ShW    = $clog2(WIDTH);
    localparam int unsigned NumSrc = NREGS + NumFixedSrc;

    logic [WIDTH-1:0]   r_q [NREGS];
    logic [WIDTH-1:0]   hi_q, lo_q, pc_q, mdr_q, y_q, zhi_q, zlo_q;
    logic [WIDTH-1:0]   bus;
    logic [NumSrc-1:0]  src_sel;
    logic [WIDTH-1:0]   src_val [NumSrc];
    logic [ShW-1:0]     shamt;
    logic [2*WIDTH-1:0] ror_t, rol_t;
    logic [WIDTH-1:0]   alu_res;
    logic               seq_idle, seq_accept, seq_valid;
    logic [WIDTH-1:0]   seq_hi, seq_lo;
    logic               zin_ok;

    // Gather bus requests and candidate values; index order is priority order.
    always_comb begin
        src_sel = '0;
        for (int i = 0; i < NumSrc; i++) begin
            src_val[i] = '0;
        end
        for (int i = 0; i < NREGS; i++) begin
            src_sel[i] = reg_out[i];
            src_val[i] = r_q[i];
        end
        src_sel[NREGS+SrcHi]  = HIout;
        src_val[NREGS+SrcHi]  = hi_q;
        src_sel[NREGS+SrcLo]  = LOout;
        src_val[NREGS+SrcLo]  = lo_q;
        src_sel[NREGS+SrcZhi] = ZHIout;
        src_val[NREGS+SrcZhi] = zhi_q;
        src_sel[NREGS+SrcZlo] = ZLOout;
        src_val[NREGS+SrcZlo] = zlo_q;
        src_sel[NREGS+SrcPc]  = PCout;
        src_val[NREGS+SrcPc]  = pc_q;
        src_sel[NREGS+SrcMdr] = MDRout;
        src_val[NREGS+SrcMdr] = mdr_q;
        src_sel[NREGS+SrcC]   = Cout;
        src_val[NREGS+SrcC]   = csign;
    end

    // Priority bus mux: scan from lowest priority so the highest active source wins.
    always_comb begin
        bus = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (src_sel[i]) begin
                bus = src_val[i];
            end
        end
    end

    assign shamt = bus[ShW-1:0];
    assign ror_t = {y_q, y_q} >> shamt;
    assign rol_t = {y_q, y_q} << shamt;

    // Single-cycle ALU; Y is the left operand, the bus the right operand.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            AluAdd:  alu_res = y_q + bus;
            AluSub:  alu_res = y_q - bus;
            AluAnd:  alu_res = y_q & bus;
            AluOr:   alu_res = y_q | bus;
            AluNot:  alu_res = ~bus;
            AluNeg:  alu_res = -bus;
            AluShr:  alu_res = y_q >> shamt;
            AluShra: alu_res = $signed(y_q) >>> shamt;
            AluShl:  alu_res = y_q << shamt;
            AluRor:  alu_res = ror_t[WIDTH-1:0];
            AluRol:  alu_res = rol_t[2*WIDTH-1:WIDTH];
            default: alu_res = '0;
        endcase
    end

    mul_div_seq #(
        .WIDTH (WIDTH)
    ) u_seq (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .op        (alu_op),
        .opa       (y_q),
        .opb       (bus),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .idle      (seq_idle),
        .accept    (seq_accept),
        .res_valid (seq_valid),
        .res_hi    (seq_hi),
        .res_lo    (seq_lo)
    );

    // The sequencer owns Z outside IDLE, and a launching start beats Zin.
    assign zin_ok = Zin && seq_idle && !seq_accept;

    // General register file.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in[i]) begin
                    r_q[i] <= bus;
                end
            end
        end
    end

    // Special registers loaded from the bus (MDR optionally from memory).
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            mdr_q <= '0;
            y_q   <= '0;
        end else begin
            if (HIin)  hi_q  <= bus;
            if (LOin)  lo_q  <= bus;
            if (PCin)  pc_q  <= bus;
            if (MDRin) mdr_q <= readMDR ? mdatain : bus;
            if (Yin)   y_q   <= bus;
        end
    end

    // Z pair: sequencer result has precedence, otherwise single-cycle ALU result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zhi_q <= '0;
            zlo_q <= '0;
        end else if (seq_valid) begin
            zhi_q <= seq_hi;
            zlo_q <= seq_lo;
        end else if (zin_ok) begin
            zhi_q <= '0;
            zlo_q <= alu_res;
        end
    end

    // Flatten the register file, R0 in the least significant slice.
    always_comb begin
        r_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            r_flat[i*WIDTH +: WIDTH] = r_q[i];
        end
    end

    assign bus_out = bus;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign PC      = pc_q;
    assign MDR     = mdr_q;
    assign RY      = y_q;
    assign ZHI     = zhi_q;
    assign ZLO     = zlo_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Scoreboard bench for datapath_gen: directed bus/register/ALU cases plus random
// ALU and MUL/DIV traffic checked against an arithmetic reference model.
module tb_datapath_gen;

    localparam int W  = 32;
    localparam int NR = 16;

    logic          clk, clr;
    logic [W-1:0]  mdatain, csign;
    logic          readMDR;
    logic [NR-1:0] reg_in, reg_out;
    logic          HIin, LOin, PCin, MDRin, Yin, Zin;
    logic          HIout, LOout, PCout, MDRout, ZHIout, ZLOout, Cout;
    logic [3:0]    alu_op;
    logic          start;
    logic          busy, done, div0;
    logic [W-1:0]  bus_out, HI, LO, PC, MDR, RY, ZHI, ZLO;
    logic [NR*W-1:0] r_flat;

    datapath_gen #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .clr(clr), .mdatain(mdatain), .readMDR(readMDR),
        .reg_in(reg_in), .reg_out(reg_out),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIout(HIout), .LOout(LOout), .PCout(PCout), .MDRout(MDRout),
        .ZHIout(ZHIout), .ZLOout(ZLOout), .Cout(Cout), .csign(csign),
        .alu_op(alu_op), .start(start), .busy(busy), .done(done), .div0(div0),
        .bus_out(bus_out), .r_flat(r_flat), .HI(HI), .LO(LO), .PC(PC), .MDR(MDR),
        .RY(RY), .ZHI(ZHI), .ZLO(ZLO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU built from the operation definitions, bit-serially for shifts.
    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] y,
                                             input logic [W-1:0] b);
        int s = int'(b[4:0]);
        logic [W-1:0] r = y;
        case (op)
            4'd0: r = y + b;
            4'd1: r = y - b;
            4'd2: r = y & b;
            4'd3: r = y | b;
            4'd4: r = ~b;
            4'd5: r = 0 - b;
            4'd6: for (int i = 0; i < s; i++) r = {1'b0, r[W-1:1]};
            4'd7: for (int i = 0; i < s; i++) r = {r[W-1], r[W-1:1]};
            4'd8: for (int i = 0; i < s; i++) r = {r[W-2:0], 1'b0};
            4'd9: for (int i = 0; i < s; i++) r = {r[0], r[W-1:1]};
            4'd10: for (int i = 0; i < s; i++) r = {r[W-2:0], r[W-1]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference MUL/DIV using wide signed arithmetic.
    task automatic seq_ref(input logic [3:0] op, input logic [W-1:0] y, input logic [W-1:0] b,
                           output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint a  = longint'($signed(y));
        longint d  = longint'($signed(b));
        logic [63:0] t;
        dz = 1'b0;
        if (op == 4'd11) begin
            t  = a * d;
            hi = t[63:32];
            lo = t[31:0];
        end else if (b == '0) begin
            hi = y;
            lo = '1;
            dz = 1'b1;
        end else begin
            t  = a / d;
            lo = t[31:0];
            t  = a % d;
            hi = t[31:0];
        end
    endtask

    // Monitor: every done cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (clr && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
            end else begin
                e = sbq.pop_front();
                chk("seq_zlo", ZLO, e.lo);
                chk("seq_zhi", ZHI, e.hi);
                chk("seq_div0", div0, e.dz);
                chk("seq_done_cycle", cyc, e.due);
                chk("seq_busy_in_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        readMDR = 0; reg_in = '0; reg_out = '0;
        HIin = 0; LOin = 0; PCin = 0; MDRin = 0; Yin = 0; Zin = 0;
        HIout = 0; LOout = 0; PCout = 0; MDRout = 0; ZHIout = 0; ZLOout = 0; Cout = 0;
        start = 0; alu_op = '0; csign = '0; mdatain = '0;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        Cout = 1; csign = v; Yin = 1;
        tick();
        Cout = 0; Yin = 0;
    endtask

    task automatic alu_check(input string name, input logic [3:0] op, input logic [W-1:0] y,
                             input logic [W-1:0] b, input logic [W-1:0] exp);
        set_y(y);
        Cout = 1; csign = b; alu_op = op; Zin = 1;
        tick();
        Cout = 0; Zin = 0;
        chk(name, ZLO, exp);
        chk({name, "_zhi"}, ZHI, 0);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [W-1:0] y, input logic [W-1:0] b,
                            input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input logic edz);
        exp_t e;
        set_y(y);
        Cout = 1; csign = b; alu_op = op; start = 1;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dz = edz; e.due = cyc + 1 + W;
            sbq.push_back(e);
        end
        tick();
        Cout = 0; start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < W + 10; i++) begin
            if (!busy && !done) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=%0b done=%0b expected idle", busy, done);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] y, b, ehi, elo;
        logic         edz;
        int           r;

        quiet();
        clr = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        chk("rst_zlo", ZLO, 0);
        chk("rst_rflat_lo", r_flat[63:0], 0);
        tick();
        clr = 1;
        tick();

        // R3 from memory through MDR, R7 from a constant.
        mdatain = 32'h5; readMDR = 1; MDRin = 1;
        tick();
        MDRin = 0; readMDR = 0;
        chk("mdr_load", MDR, 32'h5);
        MDRout = 1; reg_in = 16'h0008;
        tick();
        MDRout = 0; reg_in = '0;
        Cout = 1; csign = 32'h77; reg_in = 16'h0080;
        tick();
        Cout = 0; reg_in = '0;
        reg_out = 16'h0088; HIin = 1;
        #1;
        chk("bus_r3_over_r7", bus_out, 32'h5);
        tick();
        reg_out = '0; HIin = 0;
        chk("hi_from_r3", HI, 32'h5);
        chk("r7_unchanged", r_flat[7*W +: W], 32'h77);
        chk("r3_value", r_flat[3*W +: W], 32'h5);
        Cout = 1; csign = 32'h1234; PCin = 1;
        tick();
        PCin = 0;
        HIout = 1; PCout = 1; csign = 32'hDEAD;
        #1;
        chk("bus_hi_over_pc_c", bus_out, 32'h5);
        HIout = 0; PCout = 0;
        #1;
        chk("bus_c_only", bus_out, 32'hDEAD);
        Cout = 0;
        #1;
        chk("bus_no_source", bus_out, 0);
        tick();

        // Directed ALU cases.
        alu_check("shra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_check("rol36", 4'd10, 32'h8000_0000, 32'd36, 32'h0000_0008);
        alu_check("sub", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);

        // Mid-cycle reset with nonzero state.
        #2 clr = 0;
        #1;
        chk("mid_rst_hi", HI, 0);
        chk("mid_rst_pc", PC, 0);
        chk("mid_rst_y", RY, 0);
        chk("mid_rst_zlo", ZLO, 0);
        chk("mid_rst_rflat", r_flat, 0);
        chk("mid_rst_busy", busy, 0);
        #1 clr = 1;
        tick();

        // Random single-cycle ALU traffic.
        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 13);
            op = (r <= 10) ? 4'(r) : 4'(r + 2);
            y  = $urandom;
            b  = $urandom;
            alu_check("alu_rand", op, y, b, alu_ref(op, y, b));
        end

        // MUL -3 * 7, with an ignored second start and operand churn while running.
        start_op(4'd11, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        repeat (4) tick();
        Cout = 1; csign = 32'd1; alu_op = 4'd12; start = 1; Yin = 1;
        tick();
        Cout = 0; start = 0; Yin = 0;
        wait_idle();

        // DIV -7 / 2, then divide by zero.
        start_op(4'd12, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_idle();
        start_op(4'd12, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        tick();
        chk("div0_held", div0, 1);

        // Random MUL/DIV with operand changes during RUN.
        for (int n = 0; n < 16; n++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'd11 : 4'd12;
            y  = $urandom;
            r  = $urandom_range(0, 5);
            if (r == 0)      b = '0;
            else if (r == 1) b = 32'($urandom_range(0, 20)) - 32'd10;
            else             b = $urandom;
            seq_ref(op, y, b, ehi, elo, edz);
            start_op(op, y, b, 1, ehi, elo, edz);
            set_y($urandom);
            wait_idle();
        end

        // Abort in the middle of a run: no result, Z cleared, no done.
        start_op(4'd11, 32'd123, 32'd456, 0, '0, '0, 1'b0);
        repeat (9) tick();
        #2 clr = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_zhi", ZHI, 0);
        chk("abort_zlo", ZLO, 0);
        #1 clr = 1;
        repeat (W + 4) tick();
        chk("abort_z_stays", ZLO, 0);
        start_op(4'd11, 32'd123, 32'd456, 1, 32'd0, 32'd56088, 1'b0);
        wait_idle();

        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_gen.md
# datapath_gen

Parametrised successor of the single-bus CPU datapath: a WIDTH-bit, NREGS-deep general register file plus HI, LO, PC, MDR, Y and a 2×WIDTH Z pair, all sharing one internal bus. Adds a full ALU op set and a multi-cycle signed multiply/divide sequencer that owns ZHI/ZLO while running, with a start/busy/done handshake toward the control unit.

## Interface
- WIDTH, 32, data/bus width (≥8, power of two)
- NREGS, 16, general register count (≥2)
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  asynchronous, active-low reset; clears every register and FSM to IDLE
- mdatain  in  WIDTH  memory read data
- readMDR  in  1  MDR source: 1 = mdatain, 0 = bus
- reg_in / reg_out  in  NREGS  one-hot write enable / bus drive, per general register
- HIin, LOin, PCin, MDRin, Yin, Zin  in  1  load enables
- HIout, LOout, PCout, MDRout, ZHIout, ZLOout, Cout  in  1  bus drive selects
- csign  in  WIDTH  sign-extended constant driven onto bus by Cout
- alu_op  in  4  operation select
- start  in  1  launch MUL/DIV
- busy, done, div0  out  1  sequencer status
- bus_out  out  WIDTH  current bus value
- r_flat  out  NREGS*WIDTH  general registers, R0 in LSBs
- HI, LO, PC, MDR, RY, ZHI, ZLO  out  WIDTH  register contents

## Operation
- Bus: combinational mux; priority R0..R(NREGS-1), HI, LO, ZHI, ZLO, PC, MDR, Cout; no source → 0.
- Any enabled register loads bus_out on the edge; MDR loads per readMDR.
- alu_op: 0 ADD, 1 SUB (Y−bus), 2 AND, 3 OR, 4 NOT bus, 5 NEG bus, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL (Y shifted by bus[log2 WIDTH−1:0]), 11 MUL, 12 DIV, 13–15 result 0.
- Single-cycle ops: Zin in IDLE loads ZLO = result (mod 2^WIDTH), ZHI = 0.
- MUL: signed Y×bus, 2·WIDTH product → ZHI:ZLO.
- DIV: signed Y÷bus, truncate toward zero; ZLO = quotient, ZHI = remainder (sign of dividend).
- Divide by zero: ZLO = all ones, ZHI = dividend, div0 = 1 (held until next start or reset).
- FSM IDLE → RUN on start & alu_op∈{11,12}: latch magnitudes and signs of Y and bus, counter = 0. RUN: one shift-add / restoring-subtract step per cycle; after step WIDTH write corrected result to ZHI/ZLO → DONE. DONE → IDLE unconditionally.
- start with other alu_op, or while busy/done: ignored. Zin ignored outside IDLE. start and Zin together in IDLE with MUL/DIV: start wins.
- Y, bus and registers other than Z remain freely usable during RUN.

## Timing
- Reset: all outputs 0 (busy, done, div0 = 0; r_flat, HI, LO, PC, MDR, RY, ZHI, ZLO = 0); FSM IDLE. clr low mid-RUN aborts; Z stays 0.
- Register load latency 1 edge; bus_out 0-cycle combinational.
- start sampled at edge k: busy = 1 from after edge k until edge k+WIDTH; ZHI/ZLO valid after edge k+WIDTH; done = 1 exactly that one cycle; busy = 0 during done. Next start accepted at edge k+WIDTH+1.
- Operands taken only at edge k; later changes to Y/bus do not affect the result.

## Structure
- datapath_pkg: alu_op encodings, FSM state enum (IDLE, RUN, DONE), bus-source index constants.
- One sub-module: mul_div_seq (FSM, counter, partial remainder/product, sign fix-up, div0); ALU, bus mux and register file stay in datapath_gen.

## Test plan
- Reset: drive registers nonzero, pulse clr low mid-cycle -> all outputs 0 immediately, busy 0.
- Bus/regs: R3 = 0x0000_0005 via mdatain→MDR→bus, reg_out[3]+reg_out[7] together -> bus = R3 (priority), R7 unchanged.
- ALU: Y = 0x8000_0000, bus = 4, SHRA -> ZLO = 0xF800_0000, ZHI = 0; ROL with bus = 36 -> rotate by 4 = 0x0000_0008.
- MUL: Y = −3, bus = 7, start at edge k -> done only in cycle after edge k+32, ZHI = 0xFFFF_FFFF, ZLO = 0xFFFF_FFEB; second start during busy ignored.
- DIV: Y = −7, bus = 2 -> ZLO = 0xFFFF_FFFD, ZHI = 0xFFFF_FFFF; bus = 0 -> ZLO = 0xFFFF_FFFF, ZHI = −7, div0 = 1.
- Abort: clr low at RUN cycle 10 -> busy 0, ZHI/ZLO 0, no done; subsequent start completes normally.
